// File: rtl/fir_tdm_multichannel.sv
// ---------------------------------------------------------------------------
// fir_tdm_multichannel
//
// Time-multiplexed FIR filter. One multiplier-accumulator is shared by
// CHANNELS independent channels. Each channel keeps its own TAPS-deep delay
// line. All channels share one set of run-time loadable coefficients.
// Each accepted sample starts a TAPS-cycle MAC pass over its channel's line.
// The scaled and saturated result is then presented on a registered
// valid/ready output.
//
// Ports
//   clk                clock, rising edge
//   reset              asynchronous reset, active low
//   in_valid/in_ready  input handshake (in_ready only in IDLE)
//   in_channel         channel of the incoming sample
//   incoming_signal_x  signed input sample
//   flush              zero every delay line (IDLE only)
//   coef_we/addr/data  coefficient write port (IDLE only)
//   out_valid/ready    output handshake
//   out_channel        channel the output belongs to
//   output_signal_y    signed, scaled, saturated filter output
//   busy               high while in MAC or OUT
// ---------------------------------------------------------------------------
module fir_tdm_multichannel #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  parameter int FRAC_BITS  = 15,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int K_W       = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_channel,
  input  logic signed [WIDTH-1:0]      incoming_signal_x,
  input  logic                         flush,
  input  logic                         coef_we,
  input  logic [K_W-1:0]               coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_channel,
  output logic signed [WIDTH-1:0]      output_signal_y,
  output logic                         busy
);

  localparam int PROD_W = WIDTH + COEF_WIDTH;
  // K_W guard bits absorb the growth from summing TAPS full-precision products.
  localparam int ACC_W  = PROD_W + K_W;

  localparam logic [K_W-1:0]  K_LAST     = K_W'(TAPS - 1);
  localparam logic [K_W:0]    ADDR_LIMIT = (K_W + 1)'(TAPS);
  localparam logic [CH_W:0]   CH_LIMIT   = (CH_W + 1)'(CHANNELS);

  // Output range expressed at accumulator width, for the saturation compare.
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_reg, state_next;

  // Storage
  logic signed [WIDTH-1:0]      x_reg [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] h_reg [TAPS];

  // MAC datapath
  logic signed [ACC_W-1:0] acc_reg;
  logic [K_W-1:0]          k_reg;
  logic [CH_W-1:0]         ch_reg;

  // Registered outputs
  logic                    out_valid_reg;
  logic signed [WIDTH-1:0] y_reg;
  logic [CH_W-1:0]         out_ch_reg;

  // Control decode
  logic                idle;
  logic                handshake;
  logic                chan_ok;
  logic                addr_ok;
  logic                accept;
  logic                flush_now;
  logic                coef_wr;
  logic                last_tap;
  logic [CHANNELS-1:0] shift_en;

  assign idle      = (state_reg == IDLE);
  // in_ready is gated by reset so it reads low while reset is held.
  assign in_ready  = idle & reset;
  assign handshake = in_valid & in_ready;
  assign accept    = handshake & chan_ok;
  assign flush_now = idle & flush;
  assign coef_wr   = idle & coef_we & addr_ok;
  assign last_tap  = (k_reg == K_LAST);

  // Range checks are only needed when the index field can hold values past
  // the last channel / tap. Otherwise they are constant true.
  if ((1 << CH_W) == CHANNELS) begin : g_chan_full
    assign chan_ok = 1'b1;
  end else begin : g_chan_range
    assign chan_ok = ({1'b0, in_channel} < CH_LIMIT);
  end

  if ((1 << K_W) == TAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_range
    assign addr_ok = ({1'b0, coef_addr} < ADDR_LIMIT);
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_shift_en
    assign shift_en[gi] = accept && (in_channel == CH_W'(gi));
  end

  // -------------------------------------------------------------------------
  // Shared multiply-accumulate
  // -------------------------------------------------------------------------
  logic signed [WIDTH-1:0]      x_sel;
  logic signed [COEF_WIDTH-1:0] h_sel;
  logic signed [PROD_W-1:0]     x_ext;
  logic signed [PROD_W-1:0]     h_ext;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_next;
  logic signed [ACC_W-1:0]      shifted;
  logic signed [WIDTH-1:0]      y_sat;

  assign x_sel = x_reg[ch_reg][k_reg];
  assign h_sel = h_reg[k_reg];
  // Extend both operands to product width so the multiply is full precision.
  assign x_ext = $signed({{COEF_WIDTH{x_sel[WIDTH-1]}}, x_sel});
  assign h_ext = $signed({{WIDTH{h_sel[COEF_WIDTH-1]}}, h_sel});
  assign prod  = x_ext * h_ext;

  assign acc_next = acc_reg + $signed({{K_W{prod[PROD_W-1]}}, prod});
  assign shifted  = acc_next >>> FRAC_BITS;

  always_comb begin
    y_sat = shifted[WIDTH-1:0];
    if (shifted > Y_MAX) begin
      y_sat = Y_MAX[WIDTH-1:0];
    end else if (shifted < Y_MIN) begin
      y_sat = Y_MIN[WIDTH-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = MAC;
      MAC:     if (last_tap)  state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Accumulator, tap counter and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg       <= '0;
      k_reg         <= '0;
      ch_reg        <= '0;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      out_ch_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ch_reg  <= in_channel;
            acc_reg <= '0;
            k_reg   <= '0;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          k_reg   <= k_reg + K_W'(1);
          // The last product goes straight into the output register,
          // so out_valid rises on the TAPS-th edge after the accept.
          if (last_tap) begin
            out_valid_reg <= 1'b1;
            y_reg         <= y_sat;
            out_ch_reg    <= ch_reg;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Coefficient store. Writes are only taken in IDLE, so the coefficients
  // stay constant while a MAC pass is in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        h_reg[k] <= '0;
      end
    end else if (coef_wr) begin
      h_reg[coef_addr] <= coef_data;
    end
  end

  // -------------------------------------------------------------------------
  // Delay lines. If a flush and an accept happen on the same edge, the
  // accepted sample lands at tap 0 of a line that is otherwise zeroed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          x_reg[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (shift_en[c]) begin
          x_reg[c][0] <= incoming_signal_x;
          for (int k = 1; k < TAPS; k++) begin
            x_reg[c][k] <= flush_now ? '0 : x_reg[c][k-1];
          end
        end else if (flush_now) begin
          for (int k = 0; k < TAPS; k++) begin
            x_reg[c][k] <= '0;
          end
        end
      end
    end
  end

  assign out_valid       = out_valid_reg;
  assign output_signal_y = y_reg;
  assign out_channel     = out_ch_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_fir_tdm_multichannel.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_multichannel
//
// Directed testbench for fir_tdm_multichannel with the default parameters.
// The expected values below were worked out by hand. Inputs are driven and
// outputs are sampled on the falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_fir_tdm_multichannel;

  localparam int WIDTH      = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 8;
  localparam int CHANNELS   = 2;
  localparam int FRAC_BITS  = 15;

  logic                         clk;
  logic                         reset;
  logic                         in_valid;
  logic                         in_ready;
  logic [0:0]                   in_channel;
  logic signed [WIDTH-1:0]      incoming_signal_x;
  logic                         flush;
  logic                         coef_we;
  logic [2:0]                   coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [0:0]                   out_channel;
  logic signed [WIDTH-1:0]      output_signal_y;
  logic                         busy;

  fir_tdm_multichannel #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS),
    .CHANNELS(CHANNELS), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
    .incoming_signal_x(incoming_signal_x), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .output_signal_y(output_signal_y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Cycle counter and accept-time monitor
  int cyc = 0;
  int n_accept = 0;
  int accept_cyc = 0;
  int prev_accept_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && in_valid && in_ready) begin
      n_accept        <= n_accept + 1;
      prev_accept_cyc <= accept_cyc;
      accept_cyc      <= cyc + 1;
    end
  end

  typedef struct {
    bit do_flush;
    int ch;
    int x;
    int y;
  } vec_t;

  vec_t tbl [32];
  int   ntbl = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit f, input int ch, input int x, input int y);
    tbl[ntbl] = '{f, ch, x, y};
    ntbl++;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic load_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(k);
    coef_data = 16'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_impulse_coefs();
    for (int k = 0; k < TAPS; k++) load_coef(k, 1024 * (k + 1));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic send(input int ch, input int x);
    int n;
    n = 0;
    in_valid          = 1'b1;
    in_channel        = 1'(ch);
    incoming_signal_x = 16'(x);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_out(input string name, input int exp_ch, input int exp_y);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid got 0, required 1", name);
      return;
    end
    $display("out %s: ch=%0d y=%0d (required ch=%0d y=%0d)",
             name, out_channel, output_signal_y, exp_ch, exp_y);
    check({name, "_y"}, output_signal_y, exp_y);
    check({name, "_ch"}, out_channel, exp_ch);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_drop"}, out_valid, 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].do_flush) pulse_flush();
      send(tbl[i].ch, tbl[i].x);
      get_out($sformatf("vec%0d", i), tbl[i].ch, tbl[i].y);
    end
    ntbl = 0;
  endtask

  initial begin
    int lat, bad, n, start, y0, c0;

    reset = 1'b1;
    in_valid = 1'b0; in_channel = '0; incoming_signal_x = '0;
    flush = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    out_ready = 1'b0;
    #1 reset = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", output_signal_y, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // ---------------- impulse response and channel isolation ----------------
    load_impulse_coefs();
    add_vec(0, 0, 16384, 512);
    for (int i = 1; i < 8; i++) add_vec(0, 0, 0, 512 * (i + 1));
    add_vec(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add_vec(i == 0, 0, (i == 0) ? 16384 : 0, 512 * (i + 1));
      add_vec(0, 1, 0, 0);
    end
    run_table();

    // ---------------- step and saturation ----------------
    for (int k = 0; k < TAPS; k++) load_coef(k, 32767);
    add_vec(1, 0, 32767, 32766);
    add_vec(0, 0, 32767, 32767);
    add_vec(0, 0, 32767, 32767);
    add_vec(1, 0, -32768, -32767);
    add_vec(0, 0, -32768, -32768);
    add_vec(0, 0, -32768, -32768);
    run_table();

    // ---------------- peak throughput ----------------
    load_impulse_coefs();
    pulse_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_channel = 1'b0; incoming_signal_x = '0;
    start = n_accept;
    n = 0;
    while (n_accept < start + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("throughput_accepts", n_accept - start, 2);
    check("throughput_spacing", accept_cyc - prev_accept_cyc, TAPS + 2);
    get_out("thru_out", 0, 0);

    // ---------------- latency and backpressure ----------------
    send(0, 16384);
    check("mac_in_ready", in_ready, 0);
    check("mac_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - accept_cyc;
    check("latency", lat, TAPS);
    check("bp_y", output_signal_y, 512);
    y0 = output_signal_y;
    c0 = out_channel;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (output_signal_y != 16'(y0) || out_channel != 1'(c0) ||
          !out_valid || in_ready || !busy) bad++;
    end
    check("bp_hold_stable", bad, 0);
    in_valid = 1'b1; in_channel = 1'b0; incoming_signal_x = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drop", out_valid, 0);
    start = n_accept;
    n = 0;
    while (n_accept == start && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("bp_accept_gap_ge10", (accept_cyc - prev_accept_cyc) >= TAPS + 2, 1);
    get_out("bp_next", 0, 1024);

    // ---------------- coefficient writes during MAC are ignored ----------------
    pulse_flush();
    send(0, 16384);
    get_out("cp_prime", 0, 512);
    in_valid = 1'b1; in_channel = 1'b0; incoming_signal_x = '0;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = -16'sd5000;
    @(negedge clk);
    coef_addr = 3'd2;
    @(negedge clk);
    coef_we = 1'b0;
    get_out("cp_cur", 0, 1024);
    send(0, 0);
    get_out("cp_next", 0, 1536);

    // ---------------- flush in IDLE ----------------
    pulse_flush();
    send(0, 0);
    get_out("flush_idle", 0, 0);

    // ---------------- flush + coef write + accept on the same edge ----------------
    send(0, 16384);
    get_out("simul_prime", 0, 512);
    flush = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd2048;
    in_valid = 1'b1; in_channel = 1'b0; incoming_signal_x = 16'sd16384;
    @(negedge clk);
    flush = 1'b0; coef_we = 1'b0; in_valid = 1'b0;
    get_out("simul", 0, 1024);

    // ---------------- flush during MAC is ignored ----------------
    in_valid = 1'b1; in_channel = 1'b0; incoming_signal_x = '0;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    get_out("flush_mac", 0, 1024);

    // ---------------- reset in the middle of MAC ----------------
    send(0, 16384);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("mid_rst_no_output", bad, 0);
    check("mid_rst_in_ready_rel", in_ready, 1);
    send(1, 16384);
    get_out("mid_rst_coefs_cleared", 1, 0);
    load_impulse_coefs();
    send(0, 0);
    get_out("mid_rst_history_cleared", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_tdm_multichannel.md
Name: fir_tdm_multichannel

Overview:
- Parametrised, time-multiplexed successor to the fixed single-channel FIR filters.
- One shared multiplier-accumulator serves CHANNELS independent channels, each with its own delay line.
- Coefficients are run-time loadable. Input and output use valid/ready handshakes.
- Sits in the filter datapath in place of a fixed FIR when several low-rate streams share one filter.

Parameters:
- WIDTH, 16, sample width; signed two's complement on input and output.
- COEF_WIDTH, 16, coefficient width; signed.
- TAPS, 8, filter length; must be >= 2.
- CHANNELS, 2, number of independent channels; must be >= 1.
- FRAC_BITS, 15, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_channel  in  max(1,clog2(CHANNELS))  channel of the input sample.
- incoming_signal_x  in  WIDTH  signed input sample.
- flush  in  1  single-cycle pulse; zeroes all delay lines.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index k.
- coef_data  in  COEF_WIDTH  signed coefficient value h[k].
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_channel  out  max(1,clog2(CHANNELS))  channel of the output sample.
- output_signal_y  out  WIDTH  signed filtered output.
- busy  out  1  high in states MAC and OUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All delay lines x[c][0..TAPS-1] and all coefficients h[0..TAPS-1] are cleared to 0.
  - acc=0.
  - Outputs: out_valid=0, output_signal_y=0, out_channel=0, busy=0, in_ready=0 while reset is asserted.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready with in_channel<CHANNELS (edge E0):
    - x[ch] shifts: x[ch][k]=x[ch][k-1], then x[ch][0]=incoming_signal_x.
    - Latch ch; acc=0; k=0; go to MAC.
  - If in_channel>=CHANNELS: the sample is handshaken and dropped. No state change, no output.
- MAC:
  - in_ready=0.
  - Edges E1..E_TAPS each perform acc += x[ch][k]*h[k], then k++.
  - At E_TAPS the block goes to OUT.
  - The product is full precision, WIDTH+COEF_WIDTH bits.
  - acc width is WIDTH+COEF_WIDTH+clog2(TAPS); it never overflows.
- OUT:
  - out_valid=1.
  - output_signal_y = saturate(acc>>>FRAC_BITS) to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The shift is arithmetic (floor).
  - out_channel=ch.
  - The outputs are registered and held stable while out_ready=0.
  - On out_ready=1: out_valid drops at that edge and the block returns to IDLE.
- Latency and throughput:
  - out_valid is first high TAPS cycles after the accepting edge.
  - Peak throughput is one sample per TAPS+2 cycles.
- Coefficients:
  - coef_we is honoured only in IDLE.
  - Writes in MAC or OUT are ignored, so coefficients stay constant within one output computation.
- flush:
  - Honoured only in IDLE; otherwise ignored.
  - Zeroes all delay lines; coefficients are retained.
  - If flush and an input handshake occur together, the flush applies first and the new sample then enters the zeroed line.
- Simultaneous coef_we and input handshake in IDLE: the write completes, but the MAC that starts at this edge uses the new value.
- Reset asserted mid-MAC or mid-OUT: the computation is aborted, no output is produced, and all state is cleared as above.
- Delay lines of channels not being processed never change.

Test Plan:
- Impulse response:
  - Stimulus: load h[k]=1024*(k+1), k=0..7; feed ch0 sample 16384, then seven 0 samples.
  - Required: outputs 512,1024,1536,2048,2560,3072,3584,4096; a further 0 input gives 0.
- Channel isolation:
  - Stimulus: same coefficients as the impulse test; interleave ch0 impulse 16384 with ch1 zeros.
  - Required: ch0 outputs as in the impulse test; ch1 outputs all 0; out_channel matches each input's channel.
- Step and saturation:
  - Stimulus: set all h=32767; feed ch0 constant 32767.
  - Required: first output 32766; from the second output on, 32767 (saturated).
  - Stimulus: feed constant -32768.
  - Required: first output -32767; from the second output on, -32768.
- Latency and backpressure:
  - Stimulus: accept a sample, then hold out_ready=0 for 5 cycles.
  - Required: out_valid rises exactly 8 cycles after the accept; output and channel are stable; in_ready=0 until the out_ready handshake; the next accept is no earlier than 10 cycles after the first.
- Coefficient and flush protection:
  - Stimulus: issue coef_we during MAC.
  - Required: the current and next outputs are unchanged.
  - Stimulus: pulse flush in IDLE after non-zero history, then feed a 0 sample.
  - Required: output 0.
- Reset mid-operation:
  - Stimulus: assert reset 3 cycles into MAC.
  - Required: out_valid=0 immediately; after release, in_ready=1; a 0 input gives output 0 (history and coefficients cleared).
